// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, registered ALU operands, multicycle mult/div/mod hold.
module alu_arbiter #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [5:0]  req_op_0,
  input  logic [5:0]  req_op_1,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_0,
  input  logic [31:0] req_b_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_0,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_data,
  output logic        rsp_branch,
  output logic        rsp_overflow,
  output logic        rsp_error,
  output logic        busy,
  output logic [5:0]  alu_opCode,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  input  logic [31:0] alu_dataC,
  input  logic        alu_branchSignal,
  input  logic        alu_overflow,
  input  logic        alu_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LongCnt =
    4'(MULDIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_q;
  logic        owner_q;
  logic [3:0]  cnt_q;
  logic [5:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] data_q;
  logic        br_q, ov_q, er_q;

  logic        gnt0, gnt1, accept;
  logic        own_ready;
  logic [5:0]  sel_op;
  logic        sel_long;

  assign gnt0 = req_valid_0 &
                (~req_valid_1 | last_q);
  assign gnt1 = req_valid_1 & ~gnt0;
  assign accept = (state_q == IDLE) &
                  (gnt0 | gnt1);
  assign own_ready = owner_q ? rsp_ready_1
                             : rsp_ready_0;
  assign sel_op = gnt1 ? req_op_1 : req_op_0;
  assign sel_long = (sel_op >= 6'd4) &&
                    (sel_op <= 6'd8);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: IDLE -> EXEC -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: if (cnt_q == '0) state_d = DONE;
      DONE: if (own_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready_0 = 1'b0;
    req_ready_1 = 1'b0;
    rsp_valid_0 = 1'b0;
    rsp_valid_1 = 1'b0;
    busy        = (state_q != IDLE);
    if (state_q == IDLE) begin
      req_ready_0 = gnt0;
      req_ready_1 = gnt1;
    end
    if (state_q == DONE) begin
      rsp_valid_0 = ~owner_q;
      rsp_valid_1 = owner_q;
    end
  end

  // Operand latch, cycle counter, result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      br_q    <= 1'b0;
      ov_q    <= 1'b0;
      er_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= sel_op;
        a_q     <= gnt1 ? req_a_1 : req_a_0;
        b_q     <= gnt1 ? req_b_1 : req_b_0;
        owner_q <= gnt1;
        last_q  <= gnt1;
        cnt_q   <= sel_long ? LongCnt : 4'd0;
      end
      if (state_q == EXEC) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          data_q <= alu_dataC;
          br_q   <= alu_branchSignal;
          ov_q   <= alu_overflow;
          er_q   <= alu_error;
        end
      end
    end
  end

  assign alu_opCode   = op_q;
  assign alu_dataA    = a_q;
  assign alu_dataB    = b_q;
  assign rsp_data     = data_q;
  assign rsp_branch   = br_q;
  assign rsp_overflow = ov_q;
  assign rsp_error    = er_q;

endmodule
